// File: rtl/riscv_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : riscv_mem_stage
// Brief    : RV64I MEM stage. Issues load/store requests to data memory,
//            aligns and extends load data, and reports misalignment and bus
//            timeouts. Optional macro MEM_STORE_ACK_EN makes stores wait for
//            a memory response before completing.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_mem_stage #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] ex5_pc,
  input  logic [31:0] ex5_inst,
  input  logic [63:0] ex5_alu_result,
  input  logic [63:0] ex5_rs2_data,
  input  logic [4:0]  ex5_rd_addr,
  input  logic [2:0]  ex5_funct3,
  input  logic        ex5_valid,
  output logic        mem_stall,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [63:0] dmem_req_addr,
  output logic [7:0]  dmem_req_be,
  output logic [63:0] dmem_req_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [63:0] dmem_rsp_rdata,
  output logic [63:0] mem_pc,
  output logic [31:0] mem_inst,
  output logic [4:0]  mem_rd_addr,
  output logic [63:0] mem_wb_data,
  output logic        mem_wb_en,
  output logic        mem_exc,
  output logic [1:0]  mem_exc_cause,
  output logic        mem_valid
);

  localparam int            c_cnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [2:0]         r_funct3;
  logic [2:0]         r_off;

  logic [6:0]  w_opcode;
  logic        w_is_ld;
  logic        w_is_st;
  logic        w_writes_rd;
  logic        w_misal;
  logic [7:0]  w_size_mask;
  logic        w_accept;
  logic        w_start;
  logic        w_tmo;
  logic [63:0] w_ld_shift;
  logic [63:0] w_ld_data;

  assign mem_stall = (r_state != S_IDLE);
  assign w_opcode  = ex5_inst[6:0];
  assign w_is_ld   = (w_opcode == 7'b0000011);
  assign w_is_st   = (w_opcode == 7'b0100011);
  assign w_accept  = (r_state == S_IDLE) && ex5_valid;
  assign w_start   = w_accept && (w_is_ld || w_is_st) && !w_misal;
  assign w_tmo     = (r_state == S_WAIT) && !dmem_rsp_valid && (r_cnt == c_tmo_last);

  always_comb begin
    w_writes_rd = 1'b0;
    case (w_opcode)
      7'b0110011, 7'b0010011, 7'b0111011, 7'b0011011,
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: w_writes_rd = 1'b1;
      default:                                        w_writes_rd = 1'b0;
    endcase
  end

  always_comb begin
    w_size_mask = 8'h01;
    w_misal     = 1'b0;
    case (ex5_funct3[1:0])
      2'd0: begin w_size_mask = 8'h01; w_misal = 1'b0;                     end
      2'd1: begin w_size_mask = 8'h03; w_misal = ex5_alu_result[0];        end
      2'd2: begin w_size_mask = 8'h0F; w_misal = |ex5_alu_result[1:0];     end
      default: begin w_size_mask = 8'hFF; w_misal = |ex5_alu_result[2:0];  end
    endcase
  end

  // Response doubleword is lane-shifted down, then extended by access size.
  assign w_ld_shift = dmem_rsp_rdata >> {r_off, 3'b000};
  always_comb begin
    w_ld_data = w_ld_shift;
    case (r_funct3)
      3'b000:  w_ld_data = {{56{w_ld_shift[7]}},  w_ld_shift[7:0]};
      3'b001:  w_ld_data = {{48{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b010:  w_ld_data = {{32{w_ld_shift[31]}}, w_ld_shift[31:0]};
      3'b100:  w_ld_data = {56'd0, w_ld_shift[7:0]};
      3'b101:  w_ld_data = {48'd0, w_ld_shift[15:0]};
      3'b110:  w_ld_data = {32'd0, w_ld_shift[31:0]};
      default: w_ld_data = w_ld_shift;
    endcase
  end

  // Control FSM with reset; completion flags are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      dmem_req_valid <= 1'b0;
      mem_valid      <= 1'b0;
      mem_wb_en      <= 1'b0;
      mem_exc        <= 1'b0;
    end else begin
      mem_valid <= 1'b0;
      mem_wb_en <= 1'b0;
      mem_exc   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ex5_valid) begin
            if (!(w_is_ld || w_is_st)) begin
              mem_valid <= 1'b1;
              mem_wb_en <= w_writes_rd && (ex5_rd_addr != 5'd0);
            end else if (w_misal) begin
              mem_valid <= 1'b1;
              mem_exc   <= 1'b1;
            end else begin
              r_state        <= S_REQ;
              dmem_req_valid <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            r_cnt          <= '0;
`ifdef MEM_STORE_ACK_EN
            r_state <= S_WAIT;
`else
            if (dmem_req_we) begin
              r_state   <= S_IDLE;
              mem_valid <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
`endif
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (dmem_rsp_valid) begin
            r_state   <= S_IDLE;
            mem_valid <= 1'b1;
            mem_wb_en <= !dmem_req_we && (mem_rd_addr != 5'd0);
          end else if (w_tmo) begin
            r_state   <= S_IDLE;
            mem_valid <= 1'b1;
            mem_exc   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers: meaningful only alongside mem_valid / dmem_req_valid.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem_pc        <= ex5_pc;
      mem_inst      <= ex5_inst;
      mem_rd_addr   <= ex5_rd_addr;
      mem_wb_data   <= ex5_alu_result;
      mem_exc_cause <= {1'b0, w_is_st};
    end
    if (w_start) begin
      r_funct3       <= ex5_funct3;
      r_off          <= ex5_alu_result[2:0];
      dmem_req_we    <= w_is_st;
      dmem_req_addr  <= {ex5_alu_result[63:3], 3'b000};
      dmem_req_be    <= w_size_mask << ex5_alu_result[2:0];
      dmem_req_wdata <= ex5_rs2_data << {ex5_alu_result[2:0], 3'b000};
    end
    if ((r_state == S_WAIT) && dmem_rsp_valid && !dmem_req_we)
      mem_wb_data <= w_ld_data;
    if (w_tmo)
      mem_exc_cause <= {1'b1, dmem_req_we};
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_mem_stage
// Brief    : Directed vectors and multi-cycle sequences for riscv_mem_stage.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] ex5_pc, ex5_alu_result, ex5_rs2_data;
  logic [31:0] ex5_inst;
  logic [4:0]  ex5_rd_addr;
  logic [2:0]  ex5_funct3;
  logic        ex5_valid;
  logic        mem_stall, dmem_req_valid, dmem_req_ready, dmem_req_we;
  logic [63:0] dmem_req_addr, dmem_req_wdata;
  logic [7:0]  dmem_req_be;
  logic        dmem_rsp_valid;
  logic [63:0] dmem_rsp_rdata;
  logic [63:0] mem_pc, mem_wb_data;
  logic [31:0] mem_inst;
  logic [4:0]  mem_rd_addr;
  logic        mem_wb_en, mem_exc, mem_valid;
  logic [1:0]  mem_exc_cause;

  int checks   = 0;
  int failures = 0;

  riscv_mem_stage #(.TIMEOUT_CYCLES(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex5_pc(ex5_pc), .ex5_inst(ex5_inst), .ex5_alu_result(ex5_alu_result),
    .ex5_rs2_data(ex5_rs2_data), .ex5_rd_addr(ex5_rd_addr), .ex5_funct3(ex5_funct3),
    .ex5_valid(ex5_valid), .mem_stall(mem_stall),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_be(dmem_req_be), .dmem_req_wdata(dmem_req_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .mem_pc(mem_pc), .mem_inst(mem_inst), .mem_rd_addr(mem_rd_addr),
    .mem_wb_data(mem_wb_data), .mem_wb_en(mem_wb_en), .mem_exc(mem_exc),
    .mem_exc_cause(mem_exc_cause), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic        wb_en;
    logic        exc;
    logic [1:0]  cause;
    logic [63:0] data;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [63:0] alu, input logic [63:0] rs2, input logic [63:0] pc);
    ex5_inst       = {17'd0, f3, rd, opc};
    ex5_funct3     = f3;
    ex5_rd_addr    = rd;
    ex5_alu_result = alu;
    ex5_rs2_data   = rs2;
    ex5_pc         = pc;
    ex5_valid      = 1'b1;
  endtask

  initial begin
    int n;
    vt[0] = '{7'b0110011, 3'd0, 5'd5,  64'h1234,             1'b1, 1'b0, 2'd0, 64'h1234};
    vt[1] = '{7'b0010011, 3'd0, 5'd0,  64'h55,               1'b0, 1'b0, 2'd0, 64'h55};
    vt[2] = '{7'b1100011, 3'd0, 5'd3,  64'h1,                1'b0, 1'b0, 2'd0, 64'h1};
    vt[3] = '{7'b0110111, 3'd0, 5'd7,  64'hFFFF_F000,        1'b1, 1'b0, 2'd0, 64'hFFFF_F000};
    vt[4] = '{7'b1101111, 3'd0, 5'd1,  64'h8000_0004,        1'b1, 1'b0, 2'd0, 64'h8000_0004};
    vt[5] = '{7'b1110011, 3'd0, 5'd2,  64'h99,               1'b0, 1'b0, 2'd0, 64'h99};
    vt[6] = '{7'b0000011, 3'd3, 5'd8,  64'h4004,             1'b0, 1'b1, 2'd0, 64'h0};
    vt[7] = '{7'b0100011, 3'd2, 5'd0,  64'h4002,             1'b0, 1'b1, 2'd1, 64'h0};
    vt[8] = '{7'b0000011, 3'd1, 5'd9,  64'h1001,             1'b0, 1'b1, 2'd0, 64'h0};

    rst_n = 1'b0; ex5_valid = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    dmem_rsp_rdata = '0;
    drive(7'b0, 3'd0, 5'd0, 64'd0, 64'd0, 64'd0);
    ex5_valid = 1'b0;
    repeat (3) step();
    chk("rst_mem_valid", 64'(mem_valid), 64'd0);
    chk("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("rst_stall", 64'(mem_stall), 64'd0);
    chk("rst_wb_en", 64'(mem_wb_en), 64'd0);
    chk("rst_exc", 64'(mem_exc), 64'd0);
    rst_n = 1'b1;
    step();

    // Single-cycle vectors: pass-through and misaligned accesses.
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].opc, vt[i].f3, vt[i].rd, vt[i].alu, 64'hDEAD, 64'h100 + 64'(i * 4));
      step();
      ex5_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), 64'(mem_valid), 64'd1);
      chk($sformatf("v%0d_req", i), 64'(dmem_req_valid), 64'd0);
      chk($sformatf("v%0d_stall", i), 64'(mem_stall), 64'd0);
      chk($sformatf("v%0d_wb_en", i), 64'(mem_wb_en), 64'(vt[i].wb_en));
      chk($sformatf("v%0d_exc", i), 64'(mem_exc), 64'(vt[i].exc));
      chk($sformatf("v%0d_pc", i), mem_pc, 64'h100 + 64'(i * 4));
      if (vt[i].exc) chk($sformatf("v%0d_cause", i), 64'(mem_exc_cause), 64'(vt[i].cause));
      else           chk($sformatf("v%0d_data", i), mem_wb_data, vt[i].data);
      step();
      chk($sformatf("v%0d_pulse", i), 64'(mem_valid), 64'd0);
    end

    // LB 0x1003, response three cycles after the handshake.
    drive(7'b0000011, 3'b000, 5'd6, 64'h1003, 64'd0, 64'h200);
    step();
    ex5_valid = 1'b0;
    chk("lb_stall", 64'(mem_stall), 64'd1);
    chk("lb_req", 64'(dmem_req_valid), 64'd1);
    chk("lb_addr", dmem_req_addr, 64'h1000);
    chk("lb_be", 64'(dmem_req_be), 64'h08);
    chk("lb_we", 64'(dmem_req_we), 64'd0);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk("lb_req_drop", 64'(dmem_req_valid), 64'd0);
    chk("lb_stall_wait", 64'(mem_stall), 64'd1);
    repeat (2) step();
    chk("lb_no_early", 64'(mem_valid), 64'd0);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 64'h00000000_80FF0000;
    step();
    dmem_rsp_valid = 1'b0;
    chk("lb_valid", 64'(mem_valid), 64'd1);
    chk("lb_wb_en", 64'(mem_wb_en), 64'd1);
    chk("lb_data", mem_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_rd", 64'(mem_rd_addr), 64'd6);
    chk("lb_stall_end", 64'(mem_stall), 64'd0);

    // LWU 0x2004 with an ADD held in EX5 during the stall.
    drive(7'b0000011, 3'b110, 5'd10, 64'h2004, 64'd0, 64'h300);
    step();
    drive(7'b0110011, 3'b000, 5'd4, 64'h77, 64'd0, 64'h304);
    chk("lwu_be", 64'(dmem_req_be), 64'hF0);
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk("lwu_held", 64'(mem_valid), 64'd0);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 64'h89ABCDEF_00000000;
    step();
    dmem_rsp_valid = 1'b0;
    chk("lwu_valid", 64'(mem_valid), 64'd1);
    chk("lwu_data", mem_wb_data, 64'h0000_0000_89AB_CDEF);
    step();
    ex5_valid = 1'b0;
    chk("add_after_valid", 64'(mem_valid), 64'd1);
    chk("add_after_data", mem_wb_data, 64'h77);
    chk("add_after_pc", mem_pc, 64'h304);
    step();
    chk("add_after_once", 64'(mem_valid), 64'd0);

    // SH 0x3006 with ready held low four cycles.
    drive(7'b0100011, 3'b001, 5'd0, 64'h3006, 64'h0000_0000_0000_BEEF, 64'h400);
    step();
    ex5_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sh_req_%0d", k), 64'(dmem_req_valid), 64'd1);
      chk($sformatf("sh_addr_%0d", k), dmem_req_addr, 64'h3000);
      chk($sformatf("sh_be_%0d", k), 64'(dmem_req_be), 64'hC0);
      chk($sformatf("sh_wdata_%0d", k), dmem_req_wdata, 64'hBEEF_0000_0000_0000);
      chk($sformatf("sh_we_%0d", k), 64'(dmem_req_we), 64'd1);
      step();
    end
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    chk("sh_valid", 64'(mem_valid), 64'd1);
    chk("sh_wb_en", 64'(mem_wb_en), 64'd0);
    chk("sh_exc", 64'(mem_exc), 64'd0);
    chk("sh_req_drop", 64'(dmem_req_valid), 64'd0);
    chk("sh_stall", 64'(mem_stall), 64'd0);

    // LD with no response: timeout after 256 WAIT cycles.
    drive(7'b0000011, 3'b011, 5'd9, 64'h5000, 64'd0, 64'h500);
    step();
    ex5_valid = 1'b0;
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    n = 0;
    while (!mem_valid && n < 300) begin
      step();
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'd256);
    chk("tmo_exc", 64'(mem_exc), 64'd1);
    chk("tmo_cause", 64'(mem_exc_cause), 64'd2);
    chk("tmo_wb_en", 64'(mem_wb_en), 64'd0);
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = 64'h1;
    step();
    dmem_rsp_valid = 1'b0;
    chk("stray_valid", 64'(mem_valid), 64'd0);
    chk("stray_stall", 64'(mem_stall), 64'd0);

    // Reset during WAIT abandons the load; a late response is ignored.
    drive(7'b0000011, 3'b011, 5'd11, 64'h6000, 64'd0, 64'h600);
    step();
    ex5_valid = 1'b0;
    dmem_req_ready = 1'b1;
    step();
    dmem_req_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_req", 64'(dmem_req_valid), 64'd0);
    chk("mrst_stall", 64'(mem_stall), 64'd0);
    chk("mrst_valid", 64'(mem_valid), 64'd0);
    dmem_rsp_valid = 1'b1;
    step();
    dmem_rsp_valid = 1'b0;
    chk("mrst_late_rsp", 64'(mem_valid), 64'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
